// File: rtl/kbd_cmd_decoder.sv
// PS/2 set-2 scan-code decoder for a two-player game: prefix FSM, per-player pending headings, start/escape strobes.
// Outputs are registered one cycle after the byte or tick. Define REVERSAL_BLOCK_EN to drop 180-degree turns at commit.
module kbd_cmd_decoder #(
  parameter logic [1:0] P1_DEFAULT_DIR = 2'b01,
  parameter logic [1:0] P2_DEFAULT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       move_tick,
  input  logic       game_idle,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       p1_pending,
  output logic       p2_pending,
  output logic       start_pulse,
  output logic       esc_pulse,
  output logic [7:0] last_code
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t     r_state;
  logic [1:0] r_p1_dir, r_p2_dir, r_p1_pend_dir, r_p2_pend_dir;
  logic       r_p1_pending, r_p2_pending;
  logic       r_space_held, r_esc_held, r_start_pulse, r_esc_pulse;
  logic [7:0] r_last_code;

  logic       w_is_e0, w_is_f0, w_prefix;
  logic       w_make_std, w_make_ext, w_brk_std;
  logic       w_p1_hit, w_p2_hit;
  logic [1:0] w_p1_new, w_p2_new;
  logic       w_space_make, w_esc_make, w_space_brk, w_esc_brk;
  logic       w_p1_commit, w_p2_commit;

  assign w_is_e0    = (scan_code == 8'hE0);
  assign w_is_f0    = (scan_code == 8'hF0);
  assign w_prefix   = w_is_e0 | w_is_f0;
  assign w_make_std = scan_valid & (r_state == S_IDLE) & ~w_prefix;
  assign w_make_ext = scan_valid & (r_state == S_EXT) & ~w_prefix;
  assign w_brk_std  = scan_valid & (r_state == S_BRK) & ~w_prefix;

  assign w_space_make = w_make_std & (scan_code == 8'h29);
  assign w_esc_make   = w_make_std & (scan_code == 8'h76);
  assign w_space_brk  = w_brk_std & (scan_code == 8'h29);
  assign w_esc_brk    = w_brk_std & (scan_code == 8'h76);

  // Arrow keys only count behind E0; WASD only without it.
  always_comb begin
    w_p1_hit = 1'b0;
    w_p1_new = 2'b00;
    w_p2_hit = 1'b0;
    w_p2_new = 2'b00;
    if (w_make_std) begin
      case (scan_code)
        8'h1D: begin w_p1_hit = 1'b1; w_p1_new = 2'b00; end
        8'h23: begin w_p1_hit = 1'b1; w_p1_new = 2'b01; end
        8'h1B: begin w_p1_hit = 1'b1; w_p1_new = 2'b10; end
        8'h1C: begin w_p1_hit = 1'b1; w_p1_new = 2'b11; end
        default: ;
      endcase
    end
    if (w_make_ext) begin
      case (scan_code)
        8'h75: begin w_p2_hit = 1'b1; w_p2_new = 2'b00; end
        8'h74: begin w_p2_hit = 1'b1; w_p2_new = 2'b01; end
        8'h72: begin w_p2_hit = 1'b1; w_p2_new = 2'b10; end
        8'h6B: begin w_p2_hit = 1'b1; w_p2_new = 2'b11; end
        default: ;
      endcase
    end
  end

`ifdef REVERSAL_BLOCK_EN
  assign w_p1_commit = move_tick & r_p1_pending & ((r_p1_pend_dir ^ r_p1_dir) != 2'b10);
  assign w_p2_commit = move_tick & r_p2_pending & ((r_p2_pend_dir ^ r_p2_dir) != 2'b10);
`else
  assign w_p1_commit = move_tick & r_p1_pending;
  assign w_p2_commit = move_tick & r_p2_pending;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_p1_dir      <= P1_DEFAULT_DIR;
      r_p2_dir      <= P2_DEFAULT_DIR;
      r_p1_pend_dir <= 2'b00;
      r_p2_pend_dir <= 2'b00;
      r_p1_pending  <= 1'b0;
      r_p2_pending  <= 1'b0;
      r_space_held  <= 1'b0;
      r_esc_held    <= 1'b0;
      r_start_pulse <= 1'b0;
      r_esc_pulse   <= 1'b0;
      r_last_code   <= 8'h00;
    end else begin
      if (scan_valid) begin
        if (w_is_e0)
          r_state <= (r_state == S_EXT) ? S_IDLE : S_EXT;
        else if (w_is_f0)
          r_state <= (r_state == S_IDLE) ? S_BRK :
                     (r_state == S_EXT)  ? S_EXT_BRK : S_IDLE;
        else begin
          r_state     <= S_IDLE;
          r_last_code <= scan_code;
        end
      end

      // Held flags swallow typematic repeats until the matching break arrives.
      r_start_pulse <= w_space_make & ~r_space_held;
      r_esc_pulse   <= w_esc_make & ~r_esc_held;
      if (w_space_make)     r_space_held <= 1'b1;
      else if (w_space_brk) r_space_held <= 1'b0;
      if (w_esc_make)       r_esc_held <= 1'b1;
      else if (w_esc_brk)   r_esc_held <= 1'b0;

      if (game_idle) begin
        r_p1_dir     <= P1_DEFAULT_DIR;
        r_p2_dir     <= P2_DEFAULT_DIR;
        r_p1_pending <= 1'b0;
        r_p2_pending <= 1'b0;
      end else begin
        if (w_p1_commit) r_p1_dir <= r_p1_pend_dir;
        if (w_p2_commit) r_p2_dir <= r_p2_pend_dir;
        if (w_p1_hit) begin
          r_p1_pending  <= 1'b1;
          r_p1_pend_dir <= w_p1_new;
        end else if (move_tick) begin
          r_p1_pending <= 1'b0;
        end
        if (w_p2_hit) begin
          r_p2_pending  <= 1'b1;
          r_p2_pend_dir <= w_p2_new;
        end else if (move_tick) begin
          r_p2_pending <= 1'b0;
        end
      end
    end
  end

  assign p1_dir      = r_p1_dir;
  assign p2_dir      = r_p2_dir;
  assign p1_pending  = r_p1_pending;
  assign p2_pending  = r_p2_pending;
  assign start_pulse = r_start_pulse;
  assign esc_pulse   = r_esc_pulse;
  assign last_code   = r_last_code;

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// Bench for kbd_cmd_decoder: hand-computed vector table, then random traffic against a keystroke-level model.
module tb_kbd_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset, scan_valid, move_tick, game_idle;
  logic [7:0] scan_code;
  logic [1:0] p1_dir, p2_dir;
  logic       p1_pending, p2_pending, start_pulse, esc_pulse;
  logic [7:0] last_code;

  kbd_cmd_decoder dut (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
    .move_tick(move_tick), .game_idle(game_idle),
    .p1_dir(p1_dir), .p2_dir(p2_dir), .p1_pending(p1_pending), .p2_pending(p2_pending),
    .start_pulse(start_pulse), .esc_pulse(esc_pulse), .last_code(last_code)
  );

  always #5 clk = ~clk;

`ifdef REVERSAL_BLOCK_EN
  localparam logic [1:0] RV1 = 2'b01;
  localparam logic [1:0] RV2 = 2'b00;
  localparam bit         REV_BLK = 1'b1;
`else
  localparam logic [1:0] RV1 = 2'b11;
  localparam logic [1:0] RV2 = 2'b10;
  localparam bit         REV_BLK = 1'b0;
`endif

  typedef struct {
    logic       rst, v;
    logic [7:0] code;
    logic       tick, idle;
    logic [1:0] p1, p2;
    logic       p1p, p2p, st, esc;
    logic [7:0] last;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void add(logic rst, logic v, logic [7:0] code, logic tick, logic idle,
                              logic [1:0] p1, logic [1:0] p2, logic p1p, logic p2p,
                              logic st, logic esc, logic [7:0] last);
    vec_t t;
    t.rst = rst; t.v = v; t.code = code; t.tick = tick; t.idle = idle;
    t.p1 = p1; t.p2 = p2; t.p1p = p1p; t.p2p = p2p; t.st = st; t.esc = esc; t.last = last;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_cycle(logic rst, logic v, logic [7:0] code, logic tick, logic idle);
    reset = rst; scan_valid = v; scan_code = code; move_tick = tick; game_idle = idle;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic [1:0] e1, logic [1:0] e2, logic e1p, logic e2p,
                         logic est, logic eesc, logic [7:0] elast);
    chk({tag, "_p1_dir"}, {6'd0, p1_dir}, {6'd0, e1});
    chk({tag, "_p2_dir"}, {6'd0, p2_dir}, {6'd0, e2});
    chk({tag, "_p1_pending"}, {7'd0, p1_pending}, {7'd0, e1p});
    chk({tag, "_p2_pending"}, {7'd0, p2_pending}, {7'd0, e2p});
    chk({tag, "_start_pulse"}, {7'd0, start_pulse}, {7'd0, est});
    chk({tag, "_esc_pulse"}, {7'd0, esc_pulse}, {7'd0, eesc});
    chk({tag, "_last_code"}, last_code, elast);
  endtask

  // Keystroke-level reference: prefix seen flags, key meaning tables, pending/commit rules.
  bit         m_ext, m_brk, m_sh, m_eh, m_st, m_esc, m_p1p, m_p2p;
  logic [1:0] m_p1, m_p2, m_p1d, m_p2d;
  logic [7:0] m_last;

  function automatic void model(logic rst, logic v, logic [7:0] code, logic tick, logic idle);
    bit h1 = 0, h2 = 0, st = 0, esc = 0;
    logic [1:0] d1 = 0, d2 = 0;
    bit plain = !m_ext && !m_brk;
    bit ext_make = m_ext && !m_brk;
    bit brk_plain = m_brk && !m_ext;
    if (rst) begin
      m_ext = 0; m_brk = 0; m_sh = 0; m_eh = 0; m_st = 0; m_esc = 0;
      m_p1 = 2'b01; m_p2 = 2'b11; m_p1p = 0; m_p2p = 0; m_last = 8'h00;
      return;
    end
    if (v) begin
      if (code == 8'hE0) begin
        m_ext = !ext_make; m_brk = 0;
      end else if (code == 8'hF0) begin
        if (m_brk) begin m_ext = 0; m_brk = 0; end
        else m_brk = 1;
      end else begin
        m_last = code;
        if (plain) begin
          case (code)
            8'h1D: begin h1 = 1; d1 = 2'd0; end
            8'h23: begin h1 = 1; d1 = 2'd1; end
            8'h1B: begin h1 = 1; d1 = 2'd2; end
            8'h1C: begin h1 = 1; d1 = 2'd3; end
            8'h29: begin st = !m_sh; m_sh = 1; end
            8'h76: begin esc = !m_eh; m_eh = 1; end
            default: ;
          endcase
        end else if (ext_make) begin
          case (code)
            8'h75: begin h2 = 1; d2 = 2'd0; end
            8'h74: begin h2 = 1; d2 = 2'd1; end
            8'h72: begin h2 = 1; d2 = 2'd2; end
            8'h6B: begin h2 = 1; d2 = 2'd3; end
            default: ;
          endcase
        end else if (brk_plain) begin
          if (code == 8'h29) m_sh = 0;
          if (code == 8'h76) m_eh = 0;
        end
        m_ext = 0; m_brk = 0;
      end
    end
    m_st = st; m_esc = esc;
    if (idle) begin
      m_p1 = 2'b01; m_p2 = 2'b11; m_p1p = 0; m_p2p = 0;
    end else begin
      if (tick && m_p1p && !(REV_BLK && ((m_p1d ^ m_p1) == 2'b10))) m_p1 = m_p1d;
      if (tick && m_p2p && !(REV_BLK && ((m_p2d ^ m_p2) == 2'b10))) m_p2 = m_p2d;
      if (h1) begin m_p1p = 1; m_p1d = d1; end else if (tick) m_p1p = 0;
      if (h2) begin m_p2p = 1; m_p2d = d2; end else if (tick) m_p2p = 0;
    end
  endfunction

  logic [7:0] codes [13];

  initial begin
    reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; move_tick = 1'b0; game_idle = 1'b0;
    //  rst v  code  tk id  p1     p2     1p 2p st es last
    add(1, 0, 8'h00, 0, 0, 2'b01, 2'b11, 0, 0, 0, 0, 8'h00);
    add(0, 1, 8'hE0, 0, 0, 2'b01, 2'b11, 0, 0, 0, 0, 8'h00);
    add(0, 1, 8'h75, 0, 0, 2'b01, 2'b11, 0, 1, 0, 0, 8'h75);
    add(0, 0, 8'h00, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 8'h75);
    add(0, 1, 8'h1D, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 8'h1D);
    add(0, 1, 8'h1B, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 8'h1B);
    add(0, 0, 8'h00, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 8'h1B);
    add(0, 1, 8'h23, 0, 0, 2'b10, 2'b00, 1, 0, 0, 0, 8'h23);
    add(0, 0, 8'h00, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 8'h23);
    add(0, 1, 8'h1C, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 8'h1C);
    add(0, 0, 8'h00, 1, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h1C);
    add(0, 1, 8'h29, 0, 0, RV1,   2'b00, 0, 0, 1, 0, 8'h29);
    add(0, 1, 8'h29, 0, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h29);
    add(0, 1, 8'h29, 0, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h29);
    add(0, 1, 8'hF0, 0, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h29);
    add(0, 1, 8'h29, 0, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h29);
    add(0, 1, 8'h29, 0, 0, RV1,   2'b00, 0, 0, 1, 0, 8'h29);
    add(0, 0, 8'h00, 0, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h29);
    add(0, 1, 8'hF0, 0, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h29);
    add(0, 1, 8'h1D, 0, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h1D);
    add(0, 1, 8'h75, 0, 0, RV1,   2'b00, 0, 0, 0, 0, 8'h75);
    add(0, 0, 8'h00, 0, 1, 2'b01, 2'b11, 0, 0, 0, 0, 8'h75);
    add(0, 1, 8'h23, 0, 1, 2'b01, 2'b11, 0, 0, 0, 0, 8'h23);
    add(0, 1, 8'h76, 0, 1, 2'b01, 2'b11, 0, 0, 0, 1, 8'h76);
    add(0, 0, 8'h00, 0, 1, 2'b01, 2'b11, 0, 0, 0, 0, 8'h76);
    add(0, 1, 8'h1D, 0, 0, 2'b01, 2'b11, 1, 0, 0, 0, 8'h1D);
    add(0, 1, 8'h1B, 1, 0, 2'b00, 2'b11, 1, 0, 0, 0, 8'h1B);
    add(0, 0, 8'h00, 1, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h1B);
    add(0, 1, 8'h76, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h76);
    add(0, 1, 8'hF0, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h76);
    add(0, 1, 8'h76, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h76);
    add(0, 1, 8'h76, 0, 0, RV2,   2'b11, 0, 0, 0, 1, 8'h76);
    add(0, 0, 8'h00, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h76);
    add(0, 1, 8'hE0, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h76);
    add(0, 1, 8'h1D, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h1D);
    add(0, 1, 8'h74, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h74);
    add(0, 1, 8'hE0, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h74);
    add(0, 1, 8'hF0, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h74);
    add(0, 1, 8'h75, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h75);
    add(0, 1, 8'hE0, 0, 0, RV2,   2'b11, 0, 0, 0, 0, 8'h75);
    add(1, 1, 8'h75, 1, 0, 2'b01, 2'b11, 0, 0, 0, 0, 8'h00);
    add(0, 1, 8'h75, 0, 0, 2'b01, 2'b11, 0, 0, 0, 0, 8'h75);

    for (int i = 0; i < tbl.size(); i++) begin
      drive_cycle(tbl[i].rst, tbl[i].v, tbl[i].code, tbl[i].tick, tbl[i].idle);
      chk_all($sformatf("vec%0d", i), tbl[i].p1, tbl[i].p2, tbl[i].p1p, tbl[i].p2p,
              tbl[i].st, tbl[i].esc, tbl[i].last);
    end

    codes = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h76,
              8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};
    model(1, 0, 8'h00, 0, 0);
    drive_cycle(1, 0, 8'h00, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      logic       r_rst, r_v, r_tick, r_idle;
      logic [7:0] r_code;
      int         k;
      r_rst  = ($urandom_range(0, 199) == 0);
      r_v    = $urandom_range(0, 1) == 1;
      k      = $urandom_range(0, 12);
      r_code = (k == 12) ? 8'($urandom) : codes[k];
      r_tick = ($urandom_range(0, 5) == 0);
      r_idle = ($urandom_range(0, 9) == 0);
      model(r_rst, r_v, r_code, r_tick, r_idle);
      drive_cycle(r_rst, r_v, r_code, r_tick, r_idle);
      chk_all($sformatf("rnd%0d", n), m_p1, m_p2, m_p1p, m_p2p, m_st, m_esc, m_last);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
